// File: rtl/multicycle_ctrl_ext_pkg.sv
// Shared definitions for the extended multicycle MIPS control unit:
// state codes, ALU function codes, opcode/funct fields and exception causes.
package multicycle_ctrl_ext_pkg;

  typedef enum logic [4:0] {
    StIf    = 5'd0,
    StId    = 5'd1,
    StMemEx = 5'd2,
    StMemRd = 5'd3,
    StLwWb  = 5'd4,
    StMemWr = 5'd5,
    StRExe  = 5'd6,
    StRWb   = 5'd7,
    StBrExe = 5'd8,
    StJ     = 5'd9,
    StIExe  = 5'd10,
    StIWb   = 5'd11,
    StLuiWb = 5'd12,
    StJr    = 5'd13,
    StJal   = 5'd14,
    StJalr  = 5'd15,
    StShExe = 5'd16,
    StTrap  = 5'd17
  } state_t;

  // ALU function codes
  localparam logic [3:0] AluAnd  = 4'd0;
  localparam logic [3:0] AluOr   = 4'd1;
  localparam logic [3:0] AluAdd  = 4'd2;
  localparam logic [3:0] AluXor  = 4'd3;
  localparam logic [3:0] AluNor  = 4'd4;
  localparam logic [3:0] AluSrl  = 4'd5;
  localparam logic [3:0] AluSub  = 4'd6;
  localparam logic [3:0] AluSltu = 4'd7;
  localparam logic [3:0] AluSll  = 4'd8;
  localparam logic [3:0] AluSlt  = 4'd9;
  localparam logic [3:0] AluSra  = 4'd10;

  // Primary opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct field
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  // Exception cause codes
  localparam logic [1:0] ExcNone = 2'b00;
  localparam logic [1:0] ExcIll  = 2'b01;
  localparam logic [1:0] ExcOvf  = 2'b10;
  localparam logic [1:0] ExcBus  = 2'b11;

  // States that stall on the MIO handshake and are covered by the timeout
  function automatic logic is_wait_state(state_t s);
    return (s == StIf) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_ext_ctrl_decode.sv
// Combinational instruction decode: opcode/funct to dispatch state, ALU op and
// illegal flag. Shared by the ID dispatch and the EXE states.
module multicycle_ctrl_ext_ctrl_decode
  import multicycle_ctrl_ext_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output state_t     o_next_state,
  output logic [3:0] o_alu_op,
  output logic       o_illegal
);

  // Decode table; anything unrecognised falls through to TRAP
  always_comb begin
    o_next_state = StTrap;
    o_alu_op     = AluAdd;
    case (i_opcode)
      OpRtype: begin
        case (i_funct)
          FnAdd:  begin o_next_state = StRExe;  o_alu_op = AluAdd;  end
          FnSub:  begin o_next_state = StRExe;  o_alu_op = AluSub;  end
          FnAnd:  begin o_next_state = StRExe;  o_alu_op = AluAnd;  end
          FnOr:   begin o_next_state = StRExe;  o_alu_op = AluOr;   end
          FnXor:  begin o_next_state = StRExe;  o_alu_op = AluXor;  end
          FnNor:  begin o_next_state = StRExe;  o_alu_op = AluNor;  end
          FnSlt:  begin o_next_state = StRExe;  o_alu_op = AluSlt;  end
          FnSltu: begin o_next_state = StRExe;  o_alu_op = AluSltu; end
          FnSll:  begin o_next_state = StShExe; o_alu_op = AluSll;  end
          FnSrl:  begin o_next_state = StShExe; o_alu_op = AluSrl;  end
          FnSra:  begin o_next_state = StShExe; o_alu_op = AluSra;  end
          FnJr:   o_next_state = StJr;
          FnJalr: o_next_state = StJalr;
          default: ;
        endcase
      end
      OpAddi:  begin o_next_state = StIExe; o_alu_op = AluAdd;  end
      OpSlti:  begin o_next_state = StIExe; o_alu_op = AluSlt;  end
      OpSltiu: begin o_next_state = StIExe; o_alu_op = AluSltu; end
      OpAndi:  begin o_next_state = StIExe; o_alu_op = AluAnd;  end
      OpOri:   begin o_next_state = StIExe; o_alu_op = AluOr;   end
      OpXori:  begin o_next_state = StIExe; o_alu_op = AluXor;  end
      OpLui:   o_next_state = StLuiWb;
      OpLw,
      OpSw:    o_next_state = StMemEx;
      OpBeq,
      OpBne:   begin o_next_state = StBrExe; o_alu_op = AluSub; end
      OpJ:     o_next_state = StJ;
      OpJal:   o_next_state = StJal;
      default: ;
    endcase
  end

  assign o_illegal = (o_next_state == StTrap);

endmodule

// File: rtl/multicycle_ctrl_ext.sv
// Moore control FSM for the multicycle MIPS datapath with shift-immediate ops,
// JALR, memory-wait timeout and precise traps (illegal, overflow, bus timeout).
module multicycle_ctrl_ext
  import multicycle_ctrl_ext_pkg::*;
#(
  parameter int unsigned ALU_OP_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter bit          TRAP_ON_OVF = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Inst_in,
  input  logic                zero,
  input  logic                overflow,
  input  logic                MIO_ready,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [ALU_OP_W-1:0] ALU_operation,
  output logic [4:0]          state_out,
  output logic                CPU_MIO,
  output logic                IorD,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                Branch,
  output logic [1:0]          RegDst,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic                EPCWrite,
  output logic                exc_valid,
  output logic [1:0]          exc_cause
);

  localparam int unsigned CntW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned TmoLast = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t          r_state, w_state_nxt;
  logic [CntW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [1:0]      r_exc_cause, w_cause_nxt;
  state_t          w_dec_state;
  logic [3:0]      w_dec_alu, w_alu_op;
  logic            w_dec_illegal, w_wait_st, w_timeout, w_ovf_trap;
  logic            w_unused;

  // zero is consumed by the datapath through PCWriteCond/Branch
  assign w_unused = ^{Inst_in[25:6], zero};

  multicycle_ctrl_ext_ctrl_decode u_decode (
    .i_opcode     (Inst_in[31:26]),
    .i_funct      (Inst_in[5:0]),
    .o_next_state (w_dec_state),
    .o_alu_op     (w_dec_alu),
    .o_illegal    (w_dec_illegal)
  );

  // The cycle that would reach the limit without a handshake is the trap cycle;
  // a handshake in that same cycle wins.
  assign w_wait_st  = is_wait_state(r_state);
  assign w_timeout  = (MEM_TIMEOUT != 0) && w_wait_st && !MIO_ready &&
                      (r_wait_cnt == CntW'(TmoLast));
  assign w_ovf_trap = TRAP_ON_OVF && overflow &&
                      ((w_dec_alu == AluAdd) || (w_dec_alu == AluSub));
  assign w_wait_cnt_nxt = (w_wait_st && !MIO_ready && !w_timeout) ?
                          r_wait_cnt + CntW'(1) : '0;

  // State, wait counter and sticky cause register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIf;
      r_wait_cnt  <= '0;
      r_exc_cause <= ExcNone;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_state_nxt == StTrap) r_exc_cause <= w_cause_nxt;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = ExcNone;
    w_alu_op    = AluAnd;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    CPU_MIO     = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch      = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    EPCWrite    = 1'b0;
    exc_valid   = 1'b0;
    case (r_state)
      StIf: begin
        MemRead  = 1'b1;
        CPU_MIO  = 1'b1;
        ALUSrcB  = 2'b01;
        w_alu_op = AluAdd;
        PCWrite  = MIO_ready;
        IRWrite  = MIO_ready;
        if (MIO_ready) w_state_nxt = StId;
        else if (w_timeout) begin
          w_state_nxt = StTrap;
          w_cause_nxt = ExcBus;
        end
      end
      StId: begin
        ALUSrcB     = 2'b11;
        w_alu_op    = AluAdd;
        w_state_nxt = w_dec_state;
        if (w_dec_illegal) w_cause_nxt = ExcIll;
      end
      StMemEx: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_alu_op    = AluAdd;
        w_state_nxt = (Inst_in[31:26] == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
        if (MIO_ready) w_state_nxt = StLwWb;
        else if (w_timeout) begin
          w_state_nxt = StTrap;
          w_cause_nxt = ExcBus;
        end
      end
      StLwWb: begin
        RegWrite    = 1'b1;
        MemtoReg    = 2'b01;
        w_state_nxt = StIf;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        CPU_MIO  = 1'b1;
        if (MIO_ready) w_state_nxt = StIf;
        else if (w_timeout) begin
          w_state_nxt = StTrap;
          w_cause_nxt = ExcBus;
        end
      end
      StRExe, StShExe, StIExe: begin
        w_alu_op = w_dec_alu;
        ALUSrcA  = (r_state == StShExe) ? 2'b10 : 2'b01;
        ALUSrcB  = (r_state == StIExe) ? 2'b10 : 2'b00;
        if (w_ovf_trap) begin
          w_state_nxt = StTrap;
          w_cause_nxt = ExcOvf;
        end else begin
          w_state_nxt = (r_state == StIExe) ? StIWb : StRWb;
        end
      end
      StRWb: begin
        RegWrite    = 1'b1;
        RegDst      = 2'b01;
        w_state_nxt = StIf;
      end
      StIWb: begin
        RegWrite    = 1'b1;
        w_state_nxt = StIf;
      end
      StBrExe: begin
        w_alu_op    = AluSub;
        ALUSrcA     = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        Branch      = (Inst_in[31:26] == OpBeq);
        w_state_nxt = StIf;
      end
      StJ, StJal: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        if (r_state == StJal) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        w_state_nxt = StIf;
      end
      StJr, StJalr: begin
        // rt is assumed zero so rs + 0 is the target
        PCWrite  = 1'b1;
        ALUSrcA  = 2'b01;
        w_alu_op = AluAdd;
        if (r_state == StJalr) begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
          MemtoReg = 2'b10;
        end
        w_state_nxt = StIf;
      end
      StLuiWb: begin
        RegWrite    = 1'b1;
        MemtoReg    = 2'b11;
        w_state_nxt = StIf;
      end
      StTrap: begin
        exc_valid   = 1'b1;
        EPCWrite    = 1'b1;
        PCWrite     = 1'b1;
        PCSource    = 2'b11;
        w_state_nxt = StIf;
      end
      default: w_state_nxt = StIf;
    endcase
  end

  assign ALU_operation = ALU_OP_W'(w_alu_op);
  assign state_out     = r_state;
  assign exc_cause     = r_exc_cause;

endmodule

// File: tb/tb_multicycle_ctrl_ext.sv
// Directed bench for multicycle_ctrl_ext: each step queues the expected output
// values for the current cycle, then drains the queue against the DUT.
module tb_multicycle_ctrl_ext;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Inst_in = '0;
  logic        zero = 1'b0;
  logic        overflow = 1'b0;
  logic        MIO_ready = 1'b0;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, PCWrite;
  logic        PCWriteCond, Branch, EPCWrite, exc_valid;
  logic [3:0]  ALU_operation;
  logic [4:0]  state_out;
  logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, exc_cause;

  multicycle_ctrl_ext #(
    .ALU_OP_W    (4),
    .MEM_TIMEOUT (4),
    .TRAP_ON_OVF (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Inst_in       (Inst_in),
    .zero          (zero),
    .overflow      (overflow),
    .MIO_ready     (MIO_ready),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .ALU_operation (ALU_operation),
    .state_out     (state_out),
    .CPU_MIO       (CPU_MIO),
    .IorD          (IorD),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .PCWrite       (PCWrite),
    .PCWriteCond   (PCWriteCond),
    .Branch        (Branch),
    .RegDst        (RegDst),
    .MemtoReg      (MemtoReg),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .PCSource      (PCSource),
    .EPCWrite      (EPCWrite),
    .exc_valid     (exc_valid),
    .exc_cause     (exc_cause)
  );

  always #5 clk = ~clk;

  typedef enum int {
    KState, KMemRead, KMemWrite, KRegWrite, KPcWrite, KIrWrite, KPcwc, KBranch,
    KExcValid, KEpc, KCause, KPcSrc, KAlu, KSrcA, KSrcB, KIorD, KCpuMio, KRegDst,
    KMemtoReg
  } kind_t;

  typedef struct {
    string      tag;
    kind_t      kind;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];
  int    nvec = 0;
  int    nfail = 0;

  function automatic logic [7:0] observe(kind_t k);
    case (k)
      KState:    return 8'(state_out);
      KMemRead:  return 8'(MemRead);
      KMemWrite: return 8'(MemWrite);
      KRegWrite: return 8'(RegWrite);
      KPcWrite:  return 8'(PCWrite);
      KIrWrite:  return 8'(IRWrite);
      KPcwc:     return 8'(PCWriteCond);
      KBranch:   return 8'(Branch);
      KExcValid: return 8'(exc_valid);
      KEpc:      return 8'(EPCWrite);
      KCause:    return 8'(exc_cause);
      KPcSrc:    return 8'(PCSource);
      KAlu:      return 8'(ALU_operation);
      KSrcA:     return 8'(ALUSrcA);
      KSrcB:     return 8'(ALUSrcB);
      KIorD:     return 8'(IorD);
      KCpuMio:   return 8'(CPU_MIO);
      KRegDst:   return 8'(RegDst);
      KMemtoReg: return 8'(MemtoReg);
      default:   return 8'hxx;
    endcase
  endfunction

  task automatic ex(input string tag, input kind_t k, input int v);
    item_t it;
    it.tag  = tag;
    it.kind = k;
    it.exp  = 8'(v);
    sb.push_back(it);
  endtask

  // Compare all queued expectations well after the edge, then advance a cycle
  task automatic go();
    item_t      it;
    logic [7:0] got;
    #2;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      got = observe(it.kind);
      nvec++;
      assert (got === it.exp) else begin
        nfail++;
        $error("FAIL %s: observed %0h expected %0h", it.tag, got, it.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rinst(input logic [5:0] fn);
    return {6'h00, 20'h0, fn};
  endfunction

  function automatic logic [31:0] iinst(input logic [5:0] op);
    return {op, 26'h0};
  endfunction

  // Fetch with an immediate handshake, then the ID cycle
  task automatic fetch(input string tag, input logic [31:0] inst);
    Inst_in   = inst;
    MIO_ready = 1'b1;
    ex({tag, "_if"}, KState, 0);
    ex({tag, "_if_pcw"}, KPcWrite, 1);
    ex({tag, "_if_irw"}, KIrWrite, 1);
    go();
    MIO_ready = 1'b0;
    ex({tag, "_id"}, KState, 1);
    ex({tag, "_id_srcb"}, KSrcB, 3);
    go();
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state: IF decode with no handshake
    ex("rst_state", KState, 0);
    ex("rst_memread", KMemRead, 1);
    ex("rst_cpumio", KCpuMio, 1);
    ex("rst_iord", KIorD, 0);
    ex("rst_srca", KSrcA, 0);
    ex("rst_srcb", KSrcB, 1);
    ex("rst_alu", KAlu, 2);
    ex("rst_pcsrc", KPcSrc, 0);
    ex("rst_pcwrite", KPcWrite, 0);
    ex("rst_regwrite", KRegWrite, 0);
    ex("rst_memwrite", KMemWrite, 0);
    ex("rst_cause", KCause, 0);
    go();
    reset = 1'b0;

    // LW with three stalled MEM_RD cycles
    fetch("lw", iinst(6'h23));
    ex("lw_memex", KState, 2);
    ex("lw_memex_srca", KSrcA, 1);
    ex("lw_memex_srcb", KSrcB, 2);
    ex("lw_memex_alu", KAlu, 2);
    go();
    for (int i = 0; i < 4; i++) begin
      MIO_ready = (i == 3);
      ex("lw_memrd", KState, 3);
      ex("lw_memrd_rd", KMemRead, 1);
      ex("lw_memrd_iord", KIorD, 1);
      ex("lw_memrd_rw", KRegWrite, 0);
      go();
    end
    MIO_ready = 1'b0;
    ex("lw_wb", KState, 4);
    ex("lw_wb_rw", KRegWrite, 1);
    ex("lw_wb_m2r", KMemtoReg, 1);
    ex("lw_wb_dst", KRegDst, 0);
    go();

    // ADD overflow trap
    fetch("add", rinst(6'h20));
    overflow = 1'b1;
    ex("add_rexe", KState, 6);
    ex("add_rexe_alu", KAlu, 2);
    ex("add_rexe_rw", KRegWrite, 0);
    go();
    overflow = 1'b0;
    ex("add_trap", KState, 17);
    ex("add_trap_valid", KExcValid, 1);
    ex("add_trap_cause", KCause, 2);
    ex("add_trap_pcsrc", KPcSrc, 3);
    ex("add_trap_rw", KRegWrite, 0);
    ex("add_trap_epc", KEpc, 1);
    ex("add_trap_pcw", KPcWrite, 1);
    go();
    ex("add_after_state", KState, 0);
    ex("add_after_valid", KExcValid, 0);
    ex("add_after_cause", KCause, 2);
    ex("add_after_rw", KRegWrite, 0);

    // BNE with zero clear
    fetch("bne", iinst(6'h05));
    ex("bne_brexe", KState, 8);
    ex("bne_pcwc", KPcwc, 1);
    ex("bne_branch", KBranch, 0);
    ex("bne_alu", KAlu, 6);
    ex("bne_pcsrc", KPcSrc, 1);
    go();

    // SLL goes through SH_EXE with shamt on the A input
    fetch("sll", rinst(6'h00));
    ex("sll_shexe", KState, 16);
    ex("sll_alu", KAlu, 8);
    ex("sll_srca", KSrcA, 2);
    ex("sll_srcb", KSrcB, 0);
    go();
    ex("sll_rwb", KState, 7);
    ex("sll_rwb_rw", KRegWrite, 1);
    ex("sll_rwb_dst", KRegDst, 1);
    go();

    // JALR
    fetch("jalr", rinst(6'h09));
    ex("jalr_state", KState, 15);
    ex("jalr_pcw", KPcWrite, 1);
    ex("jalr_rw", KRegWrite, 1);
    ex("jalr_dst", KRegDst, 1);
    ex("jalr_m2r", KMemtoReg, 2);
    ex("jalr_srca", KSrcA, 1);
    go();

    // Illegal opcode
    fetch("ill", iinst(6'h3F));
    ex("ill_trap", KState, 17);
    ex("ill_cause", KCause, 1);
    ex("ill_valid", KExcValid, 1);
    go();

    // SW, handshake never comes: timeout after four wait cycles
    fetch("swto", iinst(6'h2B));
    ex("swto_memex", KState, 2);
    go();
    for (int i = 0; i < 4; i++) begin
      ex("swto_memwr", KState, 5);
      ex("swto_memwr_wr", KMemWrite, 1);
      go();
    end
    ex("swto_trap", KState, 17);
    ex("swto_cause", KCause, 3);
    ex("swto_memwrite", KMemWrite, 0);
    ex("swto_memread", KMemRead, 0);
    go();

    // SW, handshake in the fourth wait cycle: no trap
    fetch("swok", iinst(6'h2B));
    go();
    for (int i = 0; i < 4; i++) begin
      MIO_ready = (i == 3);
      ex("swok_memwr", KState, 5);
      go();
    end
    MIO_ready = 1'b0;
    ex("swok_if", KState, 0);
    ex("swok_valid", KExcValid, 0);
    ex("swok_cause", KCause, 3);
    go();

    // Reset during MEM_WR
    fetch("rstwr", iinst(6'h2B));
    go();
    reset = 1'b1;
    ex("rstwr_memwr", KState, 5);
    go();
    ex("rstwr_state", KState, 0);
    ex("rstwr_memwrite", KMemWrite, 0);
    ex("rstwr_cause", KCause, 0);
    go();
    reset = 1'b0;

    // Reset during TRAP
    fetch("rsttr", iinst(6'h3F));
    ex("rsttr_trap", KState, 17);
    ex("rsttr_cause1", KCause, 1);
    reset = 1'b1;
    go();
    ex("rsttr_state", KState, 0);
    ex("rsttr_cause", KCause, 0);
    ex("rsttr_valid", KExcValid, 0);
    go();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_ext.md
Name: multicycle_ctrl_ext

Overview:
Next-generation control unit for the multicycle MIPS datapath: a Moore FSM that sequences fetch, decode, execute, memory and writeback.
- Extends the current control with shift-immediate ops (SLL/SRL/SRA), JALR, a parametrised memory-wait timeout, and precise exception handling (illegal opcode, arithmetic overflow, bus timeout) through a TRAP state.
- Sits between the instruction register / MIO bus and the datapath muxes.

Parameters:
ALU_OP_W, 4, width of ALU_operation.
MEM_TIMEOUT, 255, maximum cycles spent in IF, MEM_RD or MEM_WR without MIO_ready before a bus error; 0 disables the timeout.
TRAP_ON_OVF, 1, when 1, overflow on ADD/SUB/ADDI traps and suppresses writeback; when 0, overflow is ignored.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
Inst_in  in  32  current instruction register contents.
zero  in  1  ALU zero flag.
overflow  in  1  ALU signed overflow flag, valid in EXE states.
MIO_ready  in  1  memory/IO handshake complete.
MemRead, MemWrite  out  1  memory strobes.
ALU_operation  out  ALU_OP_W  ALU function code. Encodings: AND=0, OR=1, ADD=2, XOR=3, NOR=4, SRL=5, SUB=6, SLTU=7, SLL=8, SLT=9, SRA=10.
state_out  out  5  current state code.
CPU_MIO, IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Branch  out  1  datapath controls with the existing meanings.
RegDst, MemtoReg, ALUSrcB, PCSource  out  2  mux selects. PCSource=11 selects the exception vector.
ALUSrcA  out  2  ALU A-input select: 00=PC, 01=rs, 10=zero-extended shamt.
EPCWrite  out  1  latch the faulting PC into EPC.
exc_valid  out  1  one-cycle pulse on TRAP entry.
exc_cause  out  2  cause code: 01=illegal, 10=overflow, 11=bus timeout. Holds its value until the next trap.

Behaviour:
Outputs and FSM:
- All outputs are a combinational decode of the registered state and Inst_in (Moore), except that PCWrite and IRWrite in IF are qualified by MIO_ready.
- States: IF=0, ID=1, MEM_EX=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EXE=6, R_WB=7, BR_EXE=8, J=9, I_EXE=10, I_WB=11, LUI_WB=12, JR=13, JAL=14, JALR=15, SH_EXE=16, TRAP=17.

Reset:
- On a clk edge with reset=1: state=IF, wait counter=0, exc_cause=00.
- Outputs are then the IF decode: MemRead=1, CPU_MIO=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALU_operation=ADD, PCSource=00, all other outputs 0.
- Reset overrides every state, including a mid-trap or mid-memory wait.

Per-state behaviour:
- IF: stays in IF until MIO_ready. On MIO_ready, PCWrite=IRWrite=1 and the next state is ID.
- ID: ALUSrcA=00, ALUSrcB=11, ADD (branch target). Dispatch by opcode/funct:
  - R-type ALU funct -> R_EXE.
  - SLL/SRL/SRA -> SH_EXE.
  - JR -> JR; JALR -> JALR.
  - ADDI/ANDI/ORI/XORI/SLTI/SLTIU -> I_EXE.
  - LUI -> LUI_WB.
  - LW/SW -> MEM_EX.
  - BEQ/BNE -> BR_EXE.
  - J -> J; JAL -> JAL.
  - Any other opcode or funct -> TRAP with cause 01.
- MEM_EX: ALUSrcA=01, ALUSrcB=10, ADD; next is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1; waits for MIO_ready -> LW_WB. LW_WB: RegWrite=1, MemtoReg=01, RegDst=00.
- MEM_WR: MemWrite=1, IorD=1; waits for MIO_ready -> IF.
- R_EXE / SH_EXE / I_EXE:
  - Drive the decoded ALU op with ALUSrcA=01/10/01 and ALUSrcB=00/00/10 respectively.
  - Next state: R_WB, R_WB, I_WB.
  - If TRAP_ON_OVF=1, the op is ADD/SUB/ADDI and overflow=1 in this cycle -> TRAP with cause 10; no writeback occurs.
- R_WB: RegWrite=1, RegDst=01. I_WB: RegWrite=1, RegDst=00.
- BR_EXE: SUB with ALUSrcA=01, ALUSrcB=00, PCWriteCond=1, PCSource=01, Branch=1 for BEQ and 0 for BNE.
- J: PCWrite=1, PCSource=10.
- JAL: J controls plus RegWrite=1, RegDst=10, MemtoReg=10.
- JR: PCWrite=1, PCSource=00, ALUSrcA=01, ALUSrcB=00, ADD with rt assumed zero.
- JALR: JR controls plus RegWrite=1, RegDst=01, MemtoReg=10.
- LUI_WB: RegWrite=1, MemtoReg=11, RegDst=00.
- All single-cycle terminal states return to IF.

Timeout and TRAP:
- The wait counter increments each cycle spent in IF, MEM_RD or MEM_WR with MIO_ready=0, and clears on leaving those states.
- When the counter reaches MEM_TIMEOUT (and MEM_TIMEOUT is nonzero) -> TRAP with cause 11; MemRead/MemWrite drop at TRAP entry.
- TRAP (one cycle): exc_valid=1, EPCWrite=1, PCWrite=1, PCSource=11, RegWrite=0; next state IF.
- MIO_ready arriving in the same cycle the counter hits the limit counts as success; no trap.

Decomposition:
- Shared package: state codes, ALU opcode constants, opcode/funct constants, exc_cause codes.
- One natural sub-module, ctrl_decode: purely combinational opcode/funct to {next-state, ALU op, illegal} decode, used by ID and the EXE states.

Test Plan:
- LW with MIO_ready held low 3 cycles in MEM_RD -> states IF, ID, MEM_EX, MEM_RD×4, LW_WB, IF; RegWrite=1 only in LW_WB.
- ADD with overflow=1, TRAP_ON_OVF=1 -> R_EXE, TRAP; exc_valid pulse, exc_cause=10, RegWrite never 1, PCSource=11.
- BNE with zero=0 -> BR_EXE has PCWriteCond=1, Branch=0, ALU_operation=6.
- Opcode 6'b111111 -> ID, TRAP; exc_cause=01.
- MEM_TIMEOUT=4, SW with MIO_ready never asserted -> TRAP after 4 wait cycles, exc_cause=11; MIO_ready on the 4th cycle instead -> IF, no trap.
- reset asserted during MEM_WR and during TRAP -> next cycle state_out=0, MemWrite=0, exc_cause=00.
